// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one 4-bit slice per clock through a
// 4-bit carry-lookahead stage, wrapped in a start/busy/done handshake.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] LAST = KW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [KW-1:0]    r_k;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic [3:0] w_a_nib;
  logic [3:0] w_b_nib;
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:1] w_c;
  logic [3:0] w_s;

  // Slice k: generate/propagate, then lookahead carries from the registered carry-in.
  always_comb begin
    w_a_nib = r_a[{r_k, 2'b00} +: 4];
    w_b_nib = r_b[{r_k, 2'b00} +: 4];
    w_g     = w_a_nib & w_b_nib;
    w_p     = w_a_nib ^ w_b_nib;
    w_c[1]  = w_g[0] | (w_p[0] & r_carry);
    w_c[2]  = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
    w_c[3]  = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
            | (w_p[2] & w_p[1] & w_p[0] & r_carry);
    w_c[4]  = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
            | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
            | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
    w_s     = w_p ^ {w_c[3:1], r_carry};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_k     <= '0;
            r_sum   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_sum[{r_k, 2'b00} +: 4] <= w_s;
          r_carry                  <= w_c[4];
          if (r_k == LAST) begin
            r_cout  <= w_c[4];
            r_ovf   <= w_c[3] ^ w_c[4];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: hand-computed results, handshake
// timing, ignored starts and asynchronous reset mid-operation.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full operation: start sampled at E0, done expected 4 edges later.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tsub, input logic tcin, input logic [15:0] esum,
                        input logic ecout, input logic eovf);
    int busy_cnt;
    int lat;
    bit seen;
    busy_cnt = 0;
    lat      = 0;
    seen     = 0;
    @(negedge clk);
    a = ta; b = tb; sub = tsub; cin = tcin; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      start = 1'b0;
      a = 16'hDEAD; b = 16'hBEEF; cin = 1'b0; sub = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1;
        lat  = k - 1;
      end
    end
    check({tag, " done seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, " busy cycles"}, busy_cnt, 4);
      check({tag, " done latency"}, lat, 4);
      check({tag, " sum"}, 32'(sum), 32'(esum));
      check({tag, " cout"}, 32'(cout), 32'(ecout));
      check({tag, " overflow"}, 32'(overflow), 32'(eovf));
      @(negedge clk);
      check({tag, " done pulse width"}, 32'(done), 32'd0);
      check({tag, " sum held"}, 32'(sum), 32'(esum));
    end
  endtask

  initial begin
    int done_cnt;
    int first_done;
    logic [15:0] first_sum;
    logic first_cout;
    logic busy_c7;
    logic [15:0] second_sum;
    logic second_cout;
    logic second_ovf;
    bit   saw_done;

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset sum", 32'(sum), 0);
    check("reset cout", 32'(cout), 0);
    check("reset ovf", 32'(overflow), 0);
    rst = 1'b0;

    run_op("add 1234+4321", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("ripple FFFF+1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("ripple FFFF+cin", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op("ovf 7FFF+1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("borrow 5-7", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("ovf 8000-1", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

    // Start re-asserted from before E2 and held: ignored until IDLE, accepted at E6.
    done_cnt = 0; first_done = 0; first_sum = '0; first_cout = 1'b0; busy_c7 = 1'b0;
    second_sum = '0; second_cout = 1'b0; second_ovf = 1'b1;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 2) begin
        a = 16'hAAAA; b = 16'h5555; cin = 1'b1; start = 1'b1;
      end
      if (c == 7) begin
        busy_c7 = busy;
        start = 1'b0;
      end
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          first_done = c;
          first_sum  = sum;
          first_cout = cout;
        end else begin
          second_sum  = sum;
          second_cout = cout;
          second_ovf  = overflow;
        end
      end
    end
    check("held start first done cycle", first_done, 5);
    check("held start first sum", 32'(first_sum), 32'h3333);
    check("held start first cout", 32'(first_cout), 0);
    check("held start accepted at E6", 32'(busy_c7), 1);
    check("held start done count", done_cnt, 2);
    check("held start second sum", 32'(second_sum), 32'h0000);
    check("held start second cout", 32'(second_cout), 1);
    check("held start second ovf", 32'(second_ovf), 0);

    run_op("pre-reset 8000-1", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

    // Asynchronous reset between E2 and E3.
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("mid-op sum partial", 32'(sum), 32'h0055);
    rst = 1'b1;
    #1;
    check("async rst busy", 32'(busy), 0);
    check("async rst done", 32'(done), 0);
    check("async rst sum", 32'(sum), 0);
    check("async rst cout", 32'(cout), 0);
    check("async rst ovf", 32'(overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    check("no activity after reset", 32'(saw_done), 0);

    run_op("post-reset 0F0F+00F1", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
